conv_window_sequencer: RTL and testbench

Initiator/feeder for the 5x5 convolution MAC unit. It walks a whole image stored in pixel RAM and, for each output pixel, gathers the 5x5 neighbourhood with zero padding. It then drives the MAC's start/done handshake, post-processes the MAC's magnitude/sign result and writes one 8-bit output pixel. It sits between the image RAMs and the MAC in the filter coprocessor and is the only block that toggles the MAC's start.

---
 rtl/conv_pkg.sv | 35 +++
 rtl/conv_addr_gen.sv | 42 ++++
 rtl/conv_window_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_conv_window_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared constants, FSM states and window-offset helper for the conv window sequencer
package conv_pkg;

  localparam int WIN       = 5;
  localparam int WIN_ELEMS = 25;
  localparam int PIX_W     = 8;
  localparam int CENTER    = 12;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    CONV,
    WRITE,
    RELEASE,
    FINISH
  } state_e;

  typedef struct packed {
    logic signed [2:0] dx;
    logic signed [2:0] dy;
  } offset_t;

  // Window element k sits at (k%5-2, k/5-2) relative to the output pixel.
  function automatic offset_t elem_offset(input logic [4:0] k);
    offset_t o;
    int      kx;
    int      ky;
    kx   = int'(k) % WIN;
    ky   = int'(k) / WIN;
    o.dx = 3'(kx - 2);
    o.dy = 3'(ky - 2);
    return o;
  endfunction

endpackage

// File: rtl/conv_addr_gen.sv
// rtl/conv_addr_gen.sv - bounds check and linear address for one 5x5 window element
module conv_addr_gen
  import conv_pkg::*;
#(
  parameter int IMG_W  = 16,
  parameter int IMG_H  = 16,
  parameter int ADDR_W = 8,
  parameter int XW     = 4,
  parameter int YW     = 4
) (
  input  logic [XW-1:0]     x_i,
  input  logic [YW-1:0]     y_i,
  input  logic [4:0]        k_i,
  output logic              in_bounds_o,
  output logic [ADDR_W-1:0] addr_o
);

  localparam int MAXD  = (IMG_W > IMG_H) ? IMG_W : IMG_H;
  localparam int CW_R  = $clog2(MAXD) + 2;
  localparam int CW    = (CW_R > 4) ? CW_R : 4;
  localparam logic [CW-1:0] W_LIM = CW'(IMG_W);
  localparam logic [CW-1:0] H_LIM = CW'(IMG_H);

  offset_t       off;
  logic [CW-1:0] sx;
  logic [CW-1:0] sy;
  logic          x_ok;
  logic          y_ok;

  assign off = elem_offset(k_i);

  // Two's-complement coordinates: the MSB flags a position left of / above the image.
  assign sx = CW'(x_i) + {{(CW-3){off.dx[2]}}, off.dx};
  assign sy = CW'(y_i) + {{(CW-3){off.dy[2]}}, off.dy};

  assign x_ok        = !sx[CW-1] && (sx < W_LIM);
  assign y_ok        = !sy[CW-1] && (sy < H_LIM);
  assign in_bounds_o = x_ok && y_ok;

  assign addr_o = in_bounds_o ? (ADDR_W'(sy) * ADDR_W'(IMG_W) + ADDR_W'(sx)) : '0;

endmodule

// File: rtl/conv_window_sequencer.sv
// rtl/conv_window_sequencer.sv - walks the image, gathers zero-padded 5x5 windows and drives the MAC handshake
module conv_window_sequencer
  import conv_pkg::*;
#(
  parameter int IMG_W  = 16,
  parameter int IMG_H  = 16,
  parameter int ADDR_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       abs_mode,
  input  logic [WIN_ELEMS*PIX_W-1:0] kernel,
  output logic                       busy,
  output logic                       done,
  output logic                       rd_en,
  output logic [ADDR_W-1:0]          rd_addr,
  input  logic [PIX_W-1:0]           rd_data,
  output logic                       wr_en,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic [PIX_W-1:0]           wr_data,
  output logic [WIN_ELEMS*PIX_W-1:0] mac_window,
  output logic [WIN_ELEMS*PIX_W-1:0] mac_kernel,
  output logic                       mac_start,
  input  logic [PIX_W-1:0]           mac_result,
  input  logic                       mac_sign,
  input  logic                       mac_done
);

  localparam int KW = WIN_ELEMS * PIX_W;
  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [4:0]    LAST_J = 5'(WIN_ELEMS);
  localparam logic [XW-1:0] X_MAX  = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_MAX  = YW'(IMG_H - 1);

  state_e             state_q;
  state_e             state_d;
  logic [XW-1:0]      x_q;
  logic [YW-1:0]      y_q;
  logic [4:0]         j_q;
  logic               inb_prev_q;
  logic               abs_q;
  logic [KW-1:0]      kernel_q;
  logic [KW-1:0]      win_q;
  logic [PIX_W-1:0]   wr_data_q;

  logic               fetch_rd;
  logic               last_pix;
  logic [4:0]         gen_k;
  logic               gen_inb;
  logic [ADDR_W-1:0]  gen_addr;

  assign fetch_rd = (state_q == FETCH) && (j_q < LAST_J);
  assign last_pix = (x_q == X_MAX) && (y_q == Y_MAX);
  // Outside the read phase the centre element yields the output pixel address.
  assign gen_k    = fetch_rd ? j_q : 5'(CENTER);

  conv_addr_gen #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .ADDR_W (ADDR_W),
    .XW     (XW),
    .YW     (YW)
  ) u_addr_gen (
    .x_i         (x_q),
    .y_i         (y_q),
    .k_i         (gen_k),
    .in_bounds_o (gen_inb),
    .addr_o      (gen_addr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = FETCH;
      FETCH:   if (j_q == LAST_J) state_d = CONV;
      CONV:    if (mac_done) state_d = WRITE;
      WRITE:   state_d = RELEASE;
      RELEASE: state_d = last_pix ? FINISH : FETCH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q        <= '0;
      y_q        <= '0;
      j_q        <= '0;
      inb_prev_q <= 1'b0;
      abs_q      <= 1'b0;
      kernel_q   <= '0;
      win_q      <= '0;
      wr_data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            kernel_q <= kernel;
            abs_q    <= abs_mode;
            x_q      <= '0;
            y_q      <= '0;
            j_q      <= '0;
          end
        end
        FETCH: begin
          j_q        <= (j_q == LAST_J) ? 5'd0 : j_q + 5'd1;
          inb_prev_q <= fetch_rd && gen_inb;
          // Read data lags its strobe by one cycle, so cycle j lands element j-1.
          for (int i = 0; i < WIN_ELEMS; i++) begin
            if (j_q == 5'(i + 1)) begin
              win_q[i*PIX_W +: PIX_W] <= inb_prev_q ? rd_data : '0;
            end
          end
        end
        CONV: begin
          if (mac_done) begin
            wr_data_q <= (abs_q || !mac_sign) ? mac_result : '0;
          end
        end
        RELEASE: begin
          if (!last_pix) begin
            if (x_q == X_MAX) begin
              x_q <= '0;
              y_q <= y_q + 1'b1;
            end else begin
              x_q <= x_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    rd_en     = 1'b0;
    rd_addr   = '0;
    wr_en     = 1'b0;
    wr_addr   = '0;
    mac_start = 1'b0;
    case (state_q)
      FETCH: begin
        busy = 1'b1;
        if (fetch_rd && gen_inb) begin
          rd_en   = 1'b1;
          rd_addr = gen_addr;
        end
      end
      CONV: begin
        busy      = 1'b1;
        mac_start = 1'b1;
      end
      WRITE: begin
        busy      = 1'b1;
        wr_en     = 1'b1;
        wr_addr   = gen_addr;
        mac_start = 1'b1;
      end
      RELEASE: busy = 1'b1;
      FINISH:  done = 1'b1;
      default: ;
    endcase
  end

  assign wr_data    = wr_data_q;
  assign mac_window = win_q;
  assign mac_kernel = kernel_q;

endmodule

// File: tb/tb_conv_window_sequencer.sv
// tb/tb_conv_window_sequencer.sv - directed table-driven bench for conv_window_sequencer
module tb_conv_window_sequencer;

  localparam int W    = 16;
  localparam int H    = 16;
  localparam int AW   = 8;
  localparam int NPIX = W * H;
  localparam int KW   = 200;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abs_mode = 1'b0;
  logic [KW-1:0] kernel = '0;
  logic          busy;
  logic          done;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic [KW-1:0] mac_window;
  logic [KW-1:0] mac_kernel;
  logic          mac_start;
  logic [7:0]    mac_result;
  logic          mac_sign;
  logic          mac_done;

  always #5 clk = ~clk;

  conv_window_sequencer #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abs_mode   (abs_mode),
    .kernel     (kernel),
    .busy       (busy),
    .done       (done),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .mac_window (mac_window),
    .mac_kernel (mac_kernel),
    .mac_start  (mac_start),
    .mac_result (mac_result),
    .mac_sign   (mac_sign),
    .mac_done   (mac_done)
  );

  logic [7:0]    img  [NPIX];
  logic [7:0]    outm [NPIX];
  int            passed = 0;
  int            total = 0;
  int            wr_cnt = 0;
  int            done_cnt = 0;
  int            rd_cnt = 0;
  int            rd_snap = 0;
  int            rise_cnt = 0;
  int            viol_overlap = 0;
  int            viol_stale = 0;
  int            viol_win = 0;
  logic          prev_start = 1'b0;
  logic [KW-1:0] prev_win = '0;
  int            mac_cnt = 0;

  function automatic logic [8:0] sat_mag(input int sum);
    int m;
    m = (sum < 0) ? -sum : sum;
    if (m > 255) m = 255;
    return {(sum < 0), m[7:0]};
  endfunction

  function automatic logic [8:0] mac_calc(input logic [KW-1:0] w, input logic [KW-1:0] k);
    int s;
    s = 0;
    for (int i = 0; i < 25; i++) s += int'(w[i*8 +: 8]) * int'($signed(k[i*8 +: 8]));
    return sat_mag(s);
  endfunction

  function automatic int ref_pix(input int x, input int y, input logic [KW-1:0] k, input logic am);
    int s;
    logic [8:0] r;
    s = 0;
    for (int dy = -2; dy <= 2; dy++) begin
      for (int dx = -2; dx <= 2; dx++) begin
        if (x + dx >= 0 && x + dx < W && y + dy >= 0 && y + dy < H)
          s += int'(img[(y+dy)*W + x + dx]) * int'($signed(k[((dy+2)*5 + dx + 2)*8 +: 8]));
      end
    end
    r = sat_mag(s);
    return (!am && r[8]) ? 0 : int'(r[7:0]);
  endfunction

  // Pixel RAM, output RAM capture and protocol monitors.
  always @(posedge clk) begin
    if (rd_en) begin
      rd_data <= img[rd_addr];
      rd_cnt  <= rd_cnt + 1;
    end
    if (wr_en) begin
      outm[wr_addr] <= wr_data;
      wr_cnt        <= wr_cnt + 1;
      if (wr_addr == 0) rd_snap <= rd_cnt;
    end
    if (done) done_cnt <= done_cnt + 1;
    if (mac_start && !prev_start) begin
      rise_cnt <= rise_cnt + 1;
      if (mac_done) viol_stale <= viol_stale + 1;
    end
    if (mac_start && rd_en) viol_overlap <= viol_overlap + 1;
    if (mac_start && prev_start && mac_window != prev_win) viol_win <= viol_win + 1;
    prev_start <= mac_start;
    prev_win   <= mac_window;
  end

  // MAC model: done rises after seven cycles of start, drops once start is released.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mac_cnt    <= 0;
      mac_done   <= 1'b0;
      mac_result <= '0;
      mac_sign   <= 1'b0;
    end else if (!mac_start) begin
      mac_cnt  <= 0;
      mac_done <= 1'b0;
    end else begin
      if (mac_cnt < 7) mac_cnt <= mac_cnt + 1;
      if (mac_cnt == 6) begin
        mac_done               <= 1'b1;
        {mac_sign, mac_result} <= mac_calc(mac_window, mac_kernel);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  task automatic fill(input int mode, input int v);
    for (int a = 0; a < NPIX; a++) img[a] = (mode == 0) ? 8'(a) : 8'(v);
  endtask

  function automatic logic [KW-1:0] kern_of(input int sel);
    logic [KW-1:0] k;
    k = '0;
    for (int i = 0; i < 25; i++) begin
      case (sel)
        0: k[i*8 +: 8] = (i == 12) ? 8'd1 : 8'd0;
        1: k[i*8 +: 8] = 8'd1;
        2: k[i*8 +: 8] = (i == 12) ? 8'hFF : 8'd0;
        default: k[i*8 +: 8] = 8'(i - 12);
      endcase
    end
    return k;
  endfunction

  task automatic start_job(input logic [KW-1:0] k, input logic am);
    @(negedge clk);
    kernel   = k;
    abs_mode = am;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", int'(busy), 1);
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (!done && n < 12000) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_done_seen"}, int'(done), 1);
    chk({nm, "_busy_low_at_done"}, int'(busy), 0);
    @(negedge clk);
  endtask

  task automatic run_full(input string nm, input int ksel, input logic am, input bit poke);
    int wb, db, rb, errs;
    logic [KW-1:0] k;
    k  = kern_of(ksel);
    wb = wr_cnt;
    db = done_cnt;
    rb = rd_cnt;
    start_job(k, am);
    if (poke) begin
      repeat (500) @(negedge clk);
      kernel   = kern_of(1);
      abs_mode = ~am;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_done(nm);
    errs = 0;
    for (int a = 0; a < NPIX; a++) if (int'(outm[a]) != ref_pix(a % W, a / W, k, am)) errs++;
    chk({nm, "_image_errors"}, errs, 0);
    chk({nm, "_writes"}, wr_cnt - wb, NPIX);
    chk({nm, "_done_pulses"}, done_cnt - db, 1);
    chk({nm, "_total_reads"}, rd_cnt - rb, 5476);
    chk({nm, "_corner_reads"}, rd_snap - rb, 9);
  endtask

  typedef struct {
    int   img_val;
    int   ksel;
    logic am;
    int   px;
    int   py;
    int   exp;
  } vec_t;

  vec_t vt[14];

  initial begin
    int wb, db, n;

    vt[0]  = '{10, 1, 1'b1, 0, 0, 90};
    vt[1]  = '{10, 1, 1'b1, 2, 0, 150};
    vt[2]  = '{10, 1, 1'b1, 1, 1, 160};
    vt[3]  = '{10, 1, 1'b1, 7, 7, 250};
    vt[4]  = '{255, 1, 1'b0, 7, 7, 255};
    vt[5]  = '{255, 1, 1'b0, 0, 0, 255};
    vt[6]  = '{255, 1, 1'b0, 15, 15, 255};
    vt[7]  = '{5, 2, 1'b0, 0, 0, 0};
    vt[8]  = '{5, 2, 1'b0, 7, 7, 0};
    vt[9]  = '{5, 2, 1'b0, 15, 15, 0};
    vt[10] = '{5, 2, 1'b1, 0, 0, 5};
    vt[11] = '{5, 2, 1'b1, 7, 7, 5};
    vt[12] = '{5, 2, 1'b1, 15, 15, 5};
    vt[13] = '{5, 2, 1'b1, 3, 12, 5};

    kernel = kern_of(1);
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_rd_en", int'(rd_en), 0);
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_mac_start", int'(mac_start), 0);
    chk("rst_rd_addr", int'(rd_addr), 0);
    chk("rst_wr_addr", int'(wr_addr), 0);
    chk("rst_wr_data", int'(wr_data), 0);
    chk("rst_window_nonzero", int'(mac_window != '0), 0);
    chk("rst_kernel_nonzero", int'(mac_kernel != '0), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    fill(0, 0);
    run_full("identity", 0, 1'b0, 1'b1);
    chk("identity_out_0", int'(outm[0]), 0);
    chk("identity_out_255", int'(outm[255]), 255);
    chk("identity_out_137", int'(outm[137]), 137);

    for (int i = 0; i < 14; i++) begin
      if (i == 0 || vt[i].img_val != vt[i-1].img_val || vt[i].ksel != vt[i-1].ksel || vt[i].am != vt[i-1].am) begin
        fill(1, vt[i].img_val);
        run_full($sformatf("job%0d", i), vt[i].ksel, vt[i].am, 1'b0);
      end
      chk($sformatf("vec%0d_out_%0d_%0d", i, vt[i].px, vt[i].py), int'(outm[vt[i].py*W + vt[i].px]), vt[i].exp);
    end

    fill(0, 0);
    wb = wr_cnt;
    db = done_cnt;
    start_job(kern_of(0), 1'b0);
    n = 0;
    while ((wr_cnt - wb < 40 || !mac_start) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("midjob_reached_conv40", int'(mac_start), 1);
    chk("midjob_writes_before", wr_cnt - wb, 40);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midjob_rst_busy", int'(busy), 0);
    chk("midjob_rst_mac_start", int'(mac_start), 0);
    chk("midjob_rst_wr_data", int'(wr_data), 0);
    chk("midjob_rst_window_nonzero", int'(mac_window != '0), 0);
    chk("midjob_rst_kernel_nonzero", int'(mac_kernel != '0), 0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    chk("midjob_no_more_writes", wr_cnt - wb, 40);
    chk("midjob_no_done", done_cnt - db, 0);
    chk("midjob_idle_after", int'(busy), 0);

    run_full("after_reset", 3, 1'b0, 1'b0);

    chk("proto_start_during_fetch", viol_overlap, 0);
    chk("proto_stale_mac_done", viol_stale, 0);
    chk("proto_window_unstable", viol_win, 0);
    chk("proto_start_rises_vs_writes", rise_cnt, wr_cnt + 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
